// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants, derived sync windows
// and the 10-bit raster coordinate type used by the timing generator.
package vga_pkg;

   localparam int VGA_H_VISIBLE = 640;
   localparam int VGA_H_FRONT   = 16;
   localparam int VGA_H_SYNC    = 96;
   localparam int VGA_H_BACK    = 48;

   localparam int VGA_V_VISIBLE = 480;
   localparam int VGA_V_FRONT   = 10;
   localparam int VGA_V_SYNC    = 2;
   localparam int VGA_V_BACK    = 33;

   localparam int VGA_H_TOTAL =
      VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
   localparam int VGA_V_TOTAL =
      VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

   localparam int VGA_HS_START = VGA_H_VISIBLE + VGA_H_FRONT;
   localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
   localparam int VGA_VS_START = VGA_V_VISIBLE + VGA_V_FRONT;
   localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

   localparam int COORD_W = 10;

   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      logic   hs;
      logic   vs;
      coord_t x;
      coord_t y;
      logic   visible;
   } pix_out_t;

   function automatic coord_t to_coord(input int v);
      return coord_t'(v);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis. Wrapping counter advanced by
// 'advance'; ports: clk, reset, advance -> count, last, in_visible, in_sync.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int TOTAL      = VGA_H_TOTAL,
   parameter int VISIBLE    = VGA_H_VISIBLE,
   parameter int SYNC_START = VGA_HS_START,
   parameter int SYNC_END   = VGA_HS_END
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   advance,
   output coord_t count,
   output logic   last,
   output logic   in_visible,
   output logic   in_sync
);

   localparam coord_t LAST_C  = to_coord(TOTAL - 1);
   localparam coord_t VIS_C   = to_coord(VISIBLE);
   localparam coord_t SYNC_LO = to_coord(SYNC_START);
   localparam coord_t SYNC_HI = to_coord(SYNC_END);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (advance) begin
         if (last) count <= '0;
         else      count <= count + coord_t'(1);
      end
   end

   assign last       = (count == LAST_C);
   assign in_visible = (count < VIS_C);
   assign in_sync    = (count >= SYNC_LO) && (count < SYNC_HI);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing from CLOCK_50 with a /2 pixel
// enable. Ports: CLOCK_50, reset -> hs, vs, x_ord, y_ord, visible,
// pixel_clk, line_start, frame_start (all registered).
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int   H_VISIBLE   = VGA_H_VISIBLE,
   parameter int   H_FRONT     = VGA_H_FRONT,
   parameter int   H_SYNC      = VGA_H_SYNC,
   parameter int   H_BACK      = VGA_H_BACK,
   parameter int   V_VISIBLE   = VGA_V_VISIBLE,
   parameter int   V_FRONT     = VGA_V_FRONT,
   parameter int   V_SYNC      = VGA_V_SYNC,
   parameter int   V_BACK      = VGA_V_BACK,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic   CLOCK_50,
   input  logic   reset,
   output logic   hs,
   output logic   vs,
   output coord_t x_ord,
   output coord_t y_ord,
   output logic   visible,
   output logic   pixel_clk,
   output logic   line_start,
   output logic   frame_start
);

   localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_START = H_VISIBLE + H_FRONT;
   localparam int VS_START = V_VISIBLE + V_FRONT;

   logic     pix_en;
   logic     running;
   logic     tick;
   logic     line_org;
   logic     frame_org;
   coord_t   h_cnt;
   coord_t   v_cnt;
   logic     h_last;
   logic     v_last;
   logic     h_vis;
   logic     v_vis;
   logic     h_sync;
   logic     v_sync;
   pix_out_t nxt;

   assign tick = pix_en;

   vga_axis_counter #(
      .TOTAL      (H_TOTAL),
      .VISIBLE    (H_VISIBLE),
      .SYNC_START (HS_START),
      .SYNC_END   (HS_START + H_SYNC)
   ) u_h (
      .clk        (CLOCK_50),
      .reset      (reset),
      .advance    (tick),
      .count      (h_cnt),
      .last       (h_last),
      .in_visible (h_vis),
      .in_sync    (h_sync)
   );

   vga_axis_counter #(
      .TOTAL      (V_TOTAL),
      .VISIBLE    (V_VISIBLE),
      .SYNC_START (VS_START),
      .SYNC_END   (VS_START + V_SYNC)
   ) u_v (
      .clk        (CLOCK_50),
      .reset      (reset),
      .advance    (tick & h_last),
      .count      (v_cnt),
      .last       (v_last),
      .in_visible (v_vis),
      .in_sync    (v_sync)
   );

   always_comb begin
      nxt         = '0;
      nxt.hs      = h_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      nxt.vs      = v_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      nxt.x       = h_cnt;
      nxt.y       = v_cnt;
      nxt.visible = h_vis & v_vis;
   end

   // Divider, pixel clock and strobes update on every edge.
   // pixel_clk only starts once the first pixel has been loaded so its
   // first rising edge lands mid-pixel. line_org/frame_org remember
   // that the counters sit on a line/frame origin (after reset or a wrap).
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         pix_en      <= 1'b0;
         running     <= 1'b0;
         pixel_clk   <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         line_org    <= 1'b1;
         frame_org   <= 1'b1;
      end else begin
         pix_en      <= ~pix_en;
         running     <= running | pix_en;
         pixel_clk   <= ~pix_en & running;
         line_start  <= tick & line_org;
         frame_start <= tick & frame_org;
         if (tick) begin
            line_org  <= h_last;
            frame_org <= h_last & v_last;
         end
      end
   end

   // Outputs carry the decode of the pixel the counters held at the tick.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         hs      <= ~SYNC_ACTIVE;
         vs      <= ~SYNC_ACTIVE;
         x_ord   <= '0;
         y_ord   <= '0;
         visible <= 1'b0;
      end else if (tick) begin
         hs      <= nxt.hs;
         vs      <= nxt.vs;
         x_ord   <= nxt.x;
         y_ord   <= nxt.y;
         visible <= nxt.visible;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen, full-size
// instances (active-low and active-high sync) plus a miniature raster.
module tb_vga_timing_gen;

   localparam int CH_V = 8, CH_F = 2, CH_S = 3, CH_B = 2;
   localparam int CV_V = 4, CV_F = 1, CV_S = 2, CV_B = 1;

   logic clk;
   logic rst_a;
   logic rst_c;

   logic       hs_a, vs_a, vis_a, pc_a, ls_a, fs_a;
   logic [9:0] x_a, y_a;
   logic       hs_b, vs_b, vis_b, pc_b, ls_b, fs_b;
   logic [9:0] x_b, y_b;
   logic       hs_c, vs_c, vis_c, pc_c, ls_c, fs_c;
   logic [9:0] x_c, y_c;

   int checks = 0;
   int errors = 0;
   int na = 0;
   int nc = 0;

   logic [25:0] qa[$];
   logic [25:0] qb[$];
   logic [25:0] qc[$];

   vga_timing_gen dut_a (
      .CLOCK_50 (clk), .reset (rst_a),
      .hs (hs_a), .vs (vs_a), .x_ord (x_a), .y_ord (y_a),
      .visible (vis_a), .pixel_clk (pc_a),
      .line_start (ls_a), .frame_start (fs_a)
   );

   vga_timing_gen #(.SYNC_ACTIVE (1'b1)) dut_b (
      .CLOCK_50 (clk), .reset (rst_a),
      .hs (hs_b), .vs (vs_b), .x_ord (x_b), .y_ord (y_b),
      .visible (vis_b), .pixel_clk (pc_b),
      .line_start (ls_b), .frame_start (fs_b)
   );

   vga_timing_gen #(
      .H_VISIBLE (CH_V), .H_FRONT (CH_F), .H_SYNC (CH_S), .H_BACK (CH_B),
      .V_VISIBLE (CV_V), .V_FRONT (CV_F), .V_SYNC (CV_S), .V_BACK (CV_B),
      .SYNC_ACTIVE (1'b0)
   ) dut_c (
      .CLOCK_50 (clk), .reset (rst_c),
      .hs (hs_c), .vs (vs_c), .x_ord (x_c), .y_ord (y_c),
      .visible (vis_c), .pixel_clk (pc_c),
      .line_start (ls_c), .frame_start (fs_c)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference raster: n = CLOCK_50 edges since reset release.
   // Even edges are ticks; tick k shows pixel k-1 in raster order.
   function automatic logic [25:0] exp_out(
      input int n, input int hv, input int hf, input int hsw, input int hb,
      input int vv, input int vf, input int vsw, input int vb,
      input logic sa);
      int ht, vt, p, x, y;
      logic h, v, vis, pc, ls, fs;
      ht = hv + hf + hsw + hb;
      vt = vv + vf + vsw + vb;
      h = ~sa; v = ~sa; x = 0; y = 0;
      vis = 1'b0; pc = 1'b0; ls = 1'b0; fs = 1'b0;
      if (n >= 2) begin
         p   = n / 2 - 1;
         x   = p % ht;
         y   = (p / ht) % vt;
         vis = (x < hv) && (y < vv);
         h   = (x >= hv + hf && x < hv + hf + hsw) ? sa : ~sa;
         v   = (y >= vv + vf && y < vv + vf + vsw) ? sa : ~sa;
         pc  = (n % 2 == 1);
         if (n % 2 == 0) begin
            ls = (x == 0);
            fs = (x == 0) && (y == 0);
         end
      end
      return {h, v, 10'(x), 10'(y), vis, pc, ls, fs};
   endfunction

   always @(posedge clk) begin
      na = rst_a ? 0 : na + 1;
      nc = rst_c ? 0 : nc + 1;
      qa.push_back(exp_out(na, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
      qb.push_back(exp_out(na, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1));
      qc.push_back(exp_out(nc, CH_V, CH_F, CH_S, CH_B,
                           CV_V, CV_F, CV_S, CV_B, 1'b0));
   end

   always @(negedge clk) begin
      if (qa.size() > 0)
         check("cyc_a", {hs_a, vs_a, x_a, y_a, vis_a, pc_a, ls_a, fs_a},
               qa.pop_front());
      if (qb.size() > 0)
         check("cyc_b", {hs_b, vs_b, x_b, y_b, vis_b, pc_b, ls_b, fs_b},
               qb.pop_front());
      if (qc.size() > 0)
         check("cyc_c", {hs_c, vs_c, x_c, y_c, vis_c, pc_c, ls_c, fs_c},
               qc.pop_front());
   end

   logic [25:0] rst_lo;
   logic [25:0] rst_hi;
   logic        pseq [1:5];
   int   hs_low, hsb_high, ls_cnt, hs_x, drop_x, maxx;
   int   cyc, vs_low, vis_bad, px, py;
   logic prev_vis, found;

   initial begin
      rst_lo = {1'b1, 1'b1, 24'd0};
      rst_hi = 26'd0;
      pseq   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      rst_a  = 1'b1;
      rst_c  = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_a", {hs_a, vs_a, x_a, y_a, vis_a, pc_a, ls_a, fs_a}, rst_lo);
      check("rst_b", {hs_b, vs_b, x_b, y_b, vis_b, pc_b, ls_b, fs_b}, rst_hi);
      #1 rst_a = 1'b0;
      rst_c = 1'b0;

      for (int i = 1; i <= 5; i++) begin
         @(posedge clk); #1;
         check("pclk_seq", pc_a, pseq[i]);
         if (i == 2) begin
            check("first_xy", {x_a, y_a}, 20'd0);
            check("first_vis", vis_a, 1'b1);
            check("first_fs", fs_a, 1'b1);
            check("first_sync_a", {hs_a, vs_a}, 2'b11);
            check("first_sync_b", {hs_b, vs_b}, 2'b00);
         end
         if (i == 3) check("fs_one_cycle", fs_a, 1'b0);
      end

      hs_low = 0; hsb_high = 0; ls_cnt = 0;
      hs_x = -1; drop_x = -1; maxx = 0; prev_vis = vis_a;
      for (int i = 0; i < 1600; i++) begin
         @(posedge clk); #1;
         if (!hs_a) begin
            if (hs_x < 0) hs_x = int'(x_a);
            hs_low++;
         end
         if (hs_b) hsb_high++;
         if (ls_a) ls_cnt++;
         if (prev_vis && !vis_a && drop_x < 0) drop_x = int'(x_a);
         if (int'(x_a) > maxx) maxx = int'(x_a);
         prev_vis = vis_a;
      end
      check("hs_low_cycles", hs_low, 192);
      check("hs_b_high_cycles", hsb_high, 192);
      check("hs_start_x", hs_x, 656);
      check("vis_drop_x", drop_x, 640);
      check("line_pulses", ls_cnt, 1);
      check("max_x", maxx, 799);

      found = 1'b0; px = 0; py = 0;
      for (int i = 0; i < 600 && !found; i++) begin
         px = int'(x_c); py = int'(y_c);
         @(posedge clk); #1;
         if (fs_c) found = 1'b1;
      end
      check("fs_wait", found, 1'b1);
      check("wrap_prev_xy", {px[9:0], py[9:0]}, {10'd14, 10'd7});
      check("wrap_xy", {x_c, y_c}, 20'd0);
      check("wrap_ls_fs", {ls_c, fs_c}, 2'b11);

      found = 1'b0; cyc = 0; vs_low = 0; vis_bad = 0; ls_cnt = 0;
      for (int i = 0; i < 1000 && !found; i++) begin
         @(posedge clk); #1;
         cyc++;
         if (!vs_c) vs_low++;
         if (ls_c) ls_cnt++;
         if (vis_c && int'(y_c) >= CV_V) vis_bad++;
         if (fs_c) found = 1'b1;
      end
      check("fs_wait2", found, 1'b1);
      check("frame_cycles", cyc, 240);
      check("vs_low_cycles", vs_low, 60);
      check("frame_lines", ls_cnt, 8);
      check("vis_below", vis_bad, 0);

      found = 1'b0;
      for (int i = 0; i < 600 && !found; i++) begin
         @(negedge clk);
         if (x_c == 10'd7 && y_c == 10'd2) found = 1'b1;
      end
      check("mid_wait", found, 1'b1);
      #1 rst_c = 1'b1;
      #1;
      check("rst_mid", {hs_c, vs_c, x_c, y_c, vis_c, pc_c, ls_c, fs_c},
            rst_lo);
      repeat (3) begin
         @(posedge clk); #1;
         check("rst_hold", {hs_c, vs_c, x_c, y_c, vis_c, pc_c, ls_c, fs_c},
               rst_lo);
      end
      @(negedge clk);
      #1 rst_c = 1'b0;
      @(posedge clk); #1;
      check("restart_e1", {vis_c, fs_c}, 2'b00);
      @(posedge clk); #1;
      check("restart_xy", {x_c, y_c}, 20'd0);
      check("restart_fs", {vis_c, ls_c, fs_c}, 3'b111);

      repeat (20) @(posedge clk);
      @(negedge clk); #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
